// File: rtl/lc3b_reg_file_pkg.sv
// Shared constants and helpers for the LC-3b general-purpose register file.
// Holds register geometry, condition-code encodings and reset values.
package lc3b_reg_file_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;
  localparam int DATA_W    = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;
  typedef logic [2:0]           cc_t;

  localparam cc_t       CC_N      = 3'b100;
  localparam cc_t       CC_Z      = 3'b010;
  localparam cc_t       CC_P      = 3'b001;
  localparam reg_data_t REG_RESET = 16'h0000;
  localparam cc_t       CC_RESET  = CC_Z;

  // One-hot NZP from a two's-complement result; exactly one bit is ever set.
  function automatic cc_t cc_from_data(input reg_data_t d);
    cc_t cc;
    if (d == '0) begin
      cc = CC_Z;
    end else if (d[DATA_W-1]) begin
      cc = CC_N;
    end else begin
      cc = CC_P;
    end
    return cc;
  endfunction

endpackage

// File: rtl/lc3b_reg_file_if.sv
// Bus bundle between decode/writeback and the register file.
// The slave modport is the register file; the master modport is its user.
interface lc3b_reg_file_if;
  import lc3b_reg_file_pkg::*;

  logic      wr_en;
  reg_idx_t  wr_sel;
  reg_data_t wr_data;
  logic      ld_cc;
  reg_idx_t  sr1_sel;
  reg_idx_t  sr2_sel;
  reg_data_t sr1_out;
  reg_data_t sr2_out;
  logic      cc_n;
  logic      cc_z;
  logic      cc_p;
  logic      mark_en;
  reg_idx_t  mark_sel;
  logic [NUM_REGS-1:0] busy;
  logic      sr1_busy;
  logic      sr2_busy;

  modport master (
    output wr_en, wr_sel, wr_data, ld_cc, sr1_sel, sr2_sel, mark_en, mark_sel,
    input  sr1_out, sr2_out, cc_n, cc_z, cc_p, busy, sr1_busy, sr2_busy
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, ld_cc, sr1_sel, sr2_sel, mark_en, mark_sel,
    output sr1_out, sr2_out, cc_n, cc_z, cc_p, busy, sr1_busy, sr2_busy
  );

endinterface

// File: rtl/lc3b_reg_file_mux16x8.sv
// 8-input, 16-bit operand select used by both register-file read ports.
module mux16x8 (
  input  logic [2:0]  i_sel,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  input  logic [15:0] i_data2,
  input  logic [15:0] i_data3,
  input  logic [15:0] i_data4,
  input  logic [15:0] i_data5,
  input  logic [15:0] i_data6,
  input  logic [15:0] i_data7,
  output logic [15:0] o_data
);

  always_comb begin
    o_data = i_data0;
    case (i_sel)
      3'd0: o_data = i_data0;
      3'd1: o_data = i_data1;
      3'd2: o_data = i_data2;
      3'd3: o_data = i_data3;
      3'd4: o_data = i_data4;
      3'd5: o_data = i_data5;
      3'd6: o_data = i_data6;
      3'd7: o_data = i_data7;
      default: o_data = i_data0;
    endcase
  end

endmodule

// File: rtl/lc3b_reg_file.sv
// LC-3b R0-R7 register file with NZP condition codes, pending-write scoreboard
// and optional same-cycle write-to-read forwarding on both read ports.
module lc3b_reg_file
  import lc3b_reg_file_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           reset,
  lc3b_reg_file_if.slave bus
);

  localparam bit LP_BYPASS = (BYPASS != 0);

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  cc_t                 r_cc;
  logic [NUM_REGS-1:0] r_busy;

  logic [NUM_REGS-1:0] w_busy_next;
  logic [WIDTH-1:0]    w_sr1_reg;
  logic [WIDTH-1:0]    w_sr2_reg;
  logic                w_sr1_fwd;
  logic                w_sr2_fwd;

  // Clear first, then set: a new producer issued in the writeback cycle wins.
  always_comb begin
    w_busy_next = r_busy;
    if (bus.wr_en) begin
      w_busy_next[bus.wr_sel] = 1'b0;
    end
    if (bus.mark_en) begin
      w_busy_next[bus.mark_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= REG_RESET;
      end
      r_cc   <= CC_RESET;
      r_busy <= '0;
    end else begin
      if (bus.wr_en) begin
        r_regs[bus.wr_sel] <= bus.wr_data;
      end
      if (bus.ld_cc) begin
        r_cc <= cc_from_data(bus.wr_data);
      end
      r_busy <= w_busy_next;
    end
  end

  mux16x8 u_sr1_mux (
    .i_sel   (bus.sr1_sel),
    .i_data0 (r_regs[0]),
    .i_data1 (r_regs[1]),
    .i_data2 (r_regs[2]),
    .i_data3 (r_regs[3]),
    .i_data4 (r_regs[4]),
    .i_data5 (r_regs[5]),
    .i_data6 (r_regs[6]),
    .i_data7 (r_regs[7]),
    .o_data  (w_sr1_reg)
  );

  mux16x8 u_sr2_mux (
    .i_sel   (bus.sr2_sel),
    .i_data0 (r_regs[0]),
    .i_data1 (r_regs[1]),
    .i_data2 (r_regs[2]),
    .i_data3 (r_regs[3]),
    .i_data4 (r_regs[4]),
    .i_data5 (r_regs[5]),
    .i_data6 (r_regs[6]),
    .i_data7 (r_regs[7]),
    .o_data  (w_sr2_reg)
  );

  assign w_sr1_fwd = LP_BYPASS && bus.wr_en && (bus.wr_sel == bus.sr1_sel);
  assign w_sr2_fwd = LP_BYPASS && bus.wr_en && (bus.wr_sel == bus.sr2_sel);

  assign bus.sr1_out  = w_sr1_fwd ? bus.wr_data : w_sr1_reg;
  assign bus.sr2_out  = w_sr2_fwd ? bus.wr_data : w_sr2_reg;
  assign bus.sr1_busy = r_busy[bus.sr1_sel] & ~w_sr1_fwd;
  assign bus.sr2_busy = r_busy[bus.sr2_sel] & ~w_sr2_fwd;

  assign {bus.cc_n, bus.cc_z, bus.cc_p} = r_cc;
  assign bus.busy = r_busy;

endmodule
